// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
// Provides the default data width, the occupancy-coded buffer state
// encoding and the popped-word counter width.
package fifo_reader_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned OCC_W         = 2;

    // State value equals buffer occupancy, so occ can be read straight off the state.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer feeding the stream interface.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   push        - capture push_data this edge (never while full without pop)
//   push_data   - word to capture
//   pop         - consumer takes the head word this edge
//   flush       - synchronous discard of all buffered words
//   head_data   - oldest buffered word (registered, holds when empty)
//   head_valid  - buffer holds at least one word (registered)
//   occ         - current occupancy 0..2
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [OCC_W-1:0] occ
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] tail_q,  tail_d;
    logic             valid_q, valid_d;

    // State and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and data movement; head keeps its last value when the buffer drains
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        unique case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        state_d = S_ONE;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d = S_EMPTY;
        end

        valid_d = (state_d != S_EMPTY);
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign occ        = OCC_W'(state_q);

endmodule

// File: rtl/fifo_reader.sv
// Read-side adapter: pulls words from a FIFO with one-cycle read latency
// and presents them as a valid/ready stream with full throughput.
// Optional feature macro: FIFO_READER_CNT_EN adds the wordCount port.
// Ports:
//   Clk, Rst_n  - clock, async active-low reset
//   EN          - allow new FIFO reads
//   Flush       - discard buffered and in-flight words
//   fifoEmpty   - upstream FIFO empty flag
//   fifoRD      - upstream read strobe (combinational)
//   fifoData    - upstream read data, valid the cycle after fifoRD
//   outData     - stream data (registered)
//   outValid    - stream valid (registered)
//   outReady    - stream ready from consumer
//   wordCount   - popped-word count, wraps, cleared by Flush (macro only)
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             EN,
    input  logic             Flush,
    input  logic             fifoEmpty,
    output logic             fifoRD,
    input  logic [WIDTH-1:0] fifoData,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    input  logic             outReady
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_W-1:0] wordCount
`endif
);

    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic             pop_c;
    logic             push_c;
    logic             fifo_rd_c;
    logic [2:0]       level_c;
    logic [2:0]       limit_c;

    // Read request: only when the word can be guaranteed a buffer slot
    always_comb begin
        pop_c      = outValid & outReady;
        level_c    = 3'(occ) + 3'(inflight_q);
        limit_c    = 3'd2 + 3'(pop_c);
        fifo_rd_c  = Rst_n & EN & ~Flush & ~fifoEmpty & (level_c < limit_c);
        inflight_d = fifo_rd_c;
        push_c     = inflight_q & ~Flush;
    end

    // In-flight tracker for the one-cycle FIFO read latency
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign fifoRD = fifo_rd_c;

    fifo_reader_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .push       (push_c),
        .push_data  (fifoData),
        .pop        (pop_c),
        .flush      (Flush),
        .head_data  (outData),
        .head_valid (outValid),
        .occ        (occ)
    );

`ifdef FIFO_READER_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Popped-word counter, wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (Flush) begin
            cnt_d = '0;
        end else if (pop_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wordCount = cnt_q;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port EN  input  1  enable; 1 allows new FIFO reads.
REQ-005 SHALL have port Flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-006 SHALL have port fifoEmpty  input  1  EMPTY flag of the upstream FIFO.
REQ-007 SHALL have port fifoRD  output  1  read strobe to the upstream FIFO.
REQ-008 SHALL have port fifoData  input  WIDTH  upstream FIFO read data, valid the cycle after fifoRD=1.
REQ-009 SHALL have port outData  output  WIDTH  stream data, registered.
REQ-010 SHALL have port outValid  output  1  stream valid, registered.
REQ-011 SHALL have port outReady  input  1  stream ready from the consumer.

Function
REQ-012 SHALL hold a 2-entry output buffer (occupancy occ 0..2) and a 1-bit inflight flag.
REQ-013 SHALL implement FSM states S_EMPTY (occ=0), S_ONE (occ=1), S_FULL (occ=2); state = occ after each edge.
REQ-014 SHALL define pop = outValid & outReady; a popped word leaves the buffer at that edge.
REQ-015 SHALL drive fifoRD = EN & ~Flush & ~fifoEmpty & ((occ + inflight - pop) < 2), combinationally.
REQ-016 SHALL set inflight <= fifoRD each edge; the word on fifoData is captured when inflight=1.
REQ-017 SHALL present the oldest buffered word on outData with outValid=1 whenever occ>0; order SHALL be FIFO order.
REQ-018 SHALL sustain one word per cycle with outReady held 1 and fifoEmpty held 0, after a 2-cycle initial latency (fifoRD cycle, capture cycle).
REQ-019 SHALL, on capture and pop in the same edge, keep occ unchanged and advance the head.
REQ-020 SHALL never capture when occ=2 and no pop occurs (guaranteed by REQ-015); capture into a full buffer is a design error.
REQ-021 SHALL, when EN falls, issue no new fifoRD but still capture an already in-flight word and keep draining to the consumer.
REQ-022 SHALL hold outData and outValid stable while outValid=1 and outReady=0.
REQ-023 SHALL, on Flush=1, force fifoRD=0, set occ=0, clear inflight, discard any word arriving that edge, and drive outValid=0 next cycle.
REQ-024 SHALL keep outData unchanged (no X) when outValid=0.

Reset
REQ-025 SHALL, while Rst_n=0, hold occ=0, inflight=0, state S_EMPTY, outValid=0, outData=0 and fifoRD=0.
REQ-026 SHALL discard any in-flight word on reset mid-operation and resume normally on the first edge after Rst_n rises.

Configuration
REQ-027 SHALL, with macro FIFO_READER_CNT_EN defined, add port wordCount  output  16  count of popped words; reset 0, +1 per pop, wraps 65535->0, cleared by Flush.
REQ-028 SHALL, without FIFO_READER_CNT_EN, omit wordCount and its counter entirely; all other behaviour identical.

Structure
REQ-029 SHALL place default WIDTH, the FSM state encoding (S_EMPTY, S_ONE, S_FULL) and the counter width 16 in package fifo_reader_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module fifo_reader_skid (push, pop, flush, data in/out, occ out); fifo_reader holds read control and the counter.

Verification
REQ-031 SHALL cover streaming: FIFO preloaded 0x11..0x18, EN=1, outReady=1 -> fifoRD high 8 consecutive cycles, outData 0x11..0x18 on consecutive cycles from cycle 2, then outValid=0.
REQ-032 SHALL cover backpressure: 4 words, outReady=0 -> exactly 2 fifoRD pulses, occ=2, outData held at word 0; outReady=1 -> remaining words in order, no loss or duplicate.
REQ-033 SHALL cover EN drop: EN falls in the cycle after a fifoRD -> that word still appears on outData, no further fifoRD while EN=0.
REQ-034 SHALL cover Flush with occ=2 and inflight=1 -> outValid=0 next cycle; next word delivered is the FIFO's following entry.
REQ-035 SHALL cover async reset mid-stream: Rst_n low between edges -> outValid=0, fifoRD=0 immediately; with FIFO_READER_CNT_EN, wordCount=0.
REQ-036 SHALL cover counter wrap (FIFO_READER_CNT_EN): 65537 pops -> wordCount=1.
